ob_lm_table: RTL and testbench

//  Price-sorted limit-order table for one book side; N slots, slot 0 = best (head).

---
 rtl/ob_lm_table.sv | 247 ++++++++++++++++++++++++
 tb/tb_ob_lm_table.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ob_lm_table.sv
// Price-sorted limit-order table for one book side; slot 0 holds the best order.
// Define OB_LM_TABLE_STATS_EN to add occupancy, high-water-mark and insert-reject counters.
module ob_lm_table #(
    parameter int unsigned N       = 16,
    parameter int unsigned LANES   = 4,
    parameter bit          IS_BID  = 1'b1,
    parameter int unsigned UID_W   = 8,
    parameter int unsigned PRICE_W = 16,
    parameter int unsigned QTY_W   = 16,
    parameter int unsigned ACC_W   = 20
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ins_vld,
    input  logic [UID_W+PRICE_W+QTY_W-1:0] ins_tbl,
    output logic                           ins_rdy,
    input  logic                           head_pop,
    input  logic                           head_upt,
    input  logic [UID_W+PRICE_W+QTY_W-1:0] head_upt_tbl,
    output logic                           head_vld_r,
    output logic [UID_W+PRICE_W+QTY_W-1:0] head_r,
    input  logic                           cancel,
    input  logic [UID_W-1:0]               cancel_uid,
    output logic                           cancel_hit_w,
    output logic [UID_W+PRICE_W+QTY_W-1:0] cancel_hit_tbl_w,
    output logic                           full_r,
    output logic                           empty_r,
    input  logic                           qry_vld,
    input  logic [PRICE_W-1:0]             qry_price,
    output logic                           qry_rdy,
    output logic                           qry_rsp_vld_r,
    output logic [ACC_W-1:0]               qry_rsp_qty_r,
    output logic                           qry_rsp_stale_r
`ifdef OB_LM_TABLE_STATS_EN
    ,
    output logic [$clog2(N+1)-1:0]         occ_r,
    output logic [$clog2(N+1)-1:0]         hwm_r,
    output logic [15:0]                    ins_rej_cnt_r
`endif
);

    localparam int unsigned TBL_W = UID_W + PRICE_W + QTY_W;
    localparam int unsigned NCH   = N / LANES;
    localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned SUM_W = ACC_W + QTY_W + $clog2(LANES) + 1;
    localparam int unsigned CNT_W = $clog2(N + 1);

    function automatic logic [PRICE_W-1:0] price_of(input logic [TBL_W-1:0] t);
        return t[QTY_W +: PRICE_W];
    endfunction

    function automatic logic [UID_W-1:0] uid_of(input logic [TBL_W-1:0] t);
        return t[QTY_W+PRICE_W +: UID_W];
    endfunction

    function automatic logic [QTY_W-1:0] qty_of(input logic [TBL_W-1:0] t);
        return t[QTY_W-1:0];
    endfunction

    // a is at-or-better than b for this book side
    function automatic logic better_eq(input logic [PRICE_W-1:0] a, input logic [PRICE_W-1:0] b);
        return IS_BID ? (a >= b) : (a <= b);
    endfunction

    logic [N-1:0]       r_vld;
    logic [N-1:0]       w_vld_d;
    logic [TBL_W-1:0]   r_tbl [N];
    logic [TBL_W-1:0]   w_tbl_d [N];
    logic [N-1:0]       w_ge;
    logic [N-1:0]       w_match;
    logic [N-1:0]       w_cut;
    logic [TBL_W-1:0]   w_hit_tbl;
    logic               w_pop_do;
    logic               w_upt_do;
    logic               w_ins_do;
    logic               w_struct;

    logic               r_busy;
    logic [IDX_W-1:0]   r_idx;
    logic [PRICE_W-1:0] r_price;
    logic [ACC_W-1:0]   r_acc;
    logic               r_stale;
    logic               w_scan;
    logic [IDX_W-1:0]   w_chunk;
    logic [PRICE_W-1:0] w_thr;
    logic [SUM_W-1:0]   w_part;
    logic [SUM_W-1:0]   w_total;
    logic [ACC_W-1:0]   w_acc_sat;
    logic               w_stale_d;

    // w_cut[k] marks slots at or below the lowest-index UID match
    always_comb begin
        logic v_seen;
        v_seen    = 1'b0;
        w_ge      = '0;
        w_match   = '0;
        w_cut     = '0;
        w_hit_tbl = '0;
        for (int k = 0; k < N; k++) begin
            w_ge[k]    = r_vld[k] & better_eq(price_of(r_tbl[k]), price_of(ins_tbl));
            w_match[k] = r_vld[k] & (uid_of(r_tbl[k]) == cancel_uid);
            if (w_match[k] && !v_seen) begin
                w_hit_tbl = r_tbl[k];
            end
            v_seen   = v_seen | w_match[k];
            w_cut[k] = v_seen;
        end
    end

    assign cancel_hit_w     = cancel & ~head_pop & (|w_match);
    assign cancel_hit_tbl_w = cancel_hit_w ? w_hit_tbl : '0;
    assign ins_rdy          = ~full_r & ~head_pop & ~cancel_hit_w & ~head_upt;
    assign w_pop_do         = head_pop & r_vld[0];
    assign w_upt_do         = head_upt & ~head_pop & ~cancel_hit_w & r_vld[0];
    assign w_ins_do         = ins_vld & ins_rdy;
    assign w_struct         = w_pop_do | cancel_hit_w | w_upt_do | w_ins_do;

    always_comb begin
        w_vld_d = r_vld;
        w_tbl_d = r_tbl;
        if (head_pop) begin
            for (int k = 0; k < N - 1; k++) begin
                w_vld_d[k] = r_vld[k+1];
                w_tbl_d[k] = r_tbl[k+1];
            end
            w_vld_d[N-1] = 1'b0;
        end else if (cancel_hit_w) begin
            for (int k = 0; k < N - 1; k++) begin
                if (w_cut[k]) begin
                    w_vld_d[k] = r_vld[k+1];
                    w_tbl_d[k] = r_tbl[k+1];
                end
            end
            if (w_cut[N-1]) begin
                w_vld_d[N-1] = 1'b0;
            end
        end else if (w_upt_do) begin
            w_tbl_d[0] = head_upt_tbl;
        end else if (w_ins_do) begin
            // w_ge is a prefix mask, so its first zero is the insert slot
            if (!w_ge[0]) begin
                w_vld_d[0] = 1'b1;
                w_tbl_d[0] = ins_tbl;
            end
            for (int k = 1; k < N; k++) begin
                if (!w_ge[k]) begin
                    if (w_ge[k-1]) begin
                        w_vld_d[k] = 1'b1;
                        w_tbl_d[k] = ins_tbl;
                    end else begin
                        w_vld_d[k] = r_vld[k-1];
                        w_tbl_d[k] = r_tbl[k-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            r_vld <= w_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        r_tbl <= w_tbl_d;
    end

    assign head_vld_r = r_vld[0];
    assign head_r     = r_tbl[0];
    assign full_r     = r_vld[N-1];
    assign empty_r    = ~r_vld[0];

    // The accept cycle scans chunk 0 against the unlatched threshold
    assign qry_rdy   = ~r_busy;
    assign w_scan    = r_busy | qry_vld;
    assign w_chunk   = r_busy ? r_idx : '0;
    assign w_thr     = r_busy ? r_price : qry_price;
    assign w_stale_d = (r_busy & r_stale) | w_struct;

    always_comb begin
        w_part = '0;
        for (int k = 0; k < N; k++) begin
            if ((k / LANES) == int'(w_chunk) && r_vld[k] && better_eq(price_of(r_tbl[k]), w_thr)) begin
                w_part = w_part + SUM_W'(qty_of(r_tbl[k]));
            end
        end
        w_total   = (r_busy ? SUM_W'(r_acc) : '0) + w_part;
        w_acc_sat = (w_total > SUM_W'({ACC_W{1'b1}})) ? {ACC_W{1'b1}} : w_total[ACC_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy          <= 1'b0;
            r_idx           <= '0;
            r_price         <= '0;
            r_acc           <= '0;
            r_stale         <= 1'b0;
            qry_rsp_vld_r   <= 1'b0;
            qry_rsp_qty_r   <= '0;
            qry_rsp_stale_r <= 1'b0;
        end else begin
            qry_rsp_vld_r <= 1'b0;
            if (w_scan) begin
                if (!r_busy) begin
                    r_price <= qry_price;
                end
                if (w_chunk == IDX_W'(NCH - 1)) begin
                    r_busy          <= 1'b0;
                    qry_rsp_vld_r   <= 1'b1;
                    qry_rsp_qty_r   <= w_acc_sat;
                    qry_rsp_stale_r <= w_stale_d;
                end else begin
                    r_busy  <= 1'b1;
                    r_idx   <= w_chunk + IDX_W'(1);
                    r_acc   <= w_acc_sat;
                    r_stale <= w_stale_d;
                end
            end
        end
    end

`ifdef OB_LM_TABLE_STATS_EN
    logic [CNT_W-1:0] w_occ_d;

    assign w_occ_d = CNT_W'($countones(w_vld_d));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_r         <= '0;
            hwm_r         <= '0;
            ins_rej_cnt_r <= '0;
        end else begin
            occ_r <= w_occ_d;
            if (w_occ_d > hwm_r) begin
                hwm_r <= w_occ_d;
            end
            if (ins_vld && !ins_rdy && ins_rej_cnt_r != 16'hffff) begin
                ins_rej_cnt_r <= ins_rej_cnt_r + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ob_lm_table.sv
// Bench for ob_lm_table (N=4, LANES=2, bid side): queue-based reference model plus a
// response scoreboard drained by a monitor running alongside the stimulus.
module tb_ob_lm_table;

    localparam int unsigned N       = 4;
    localparam int unsigned LANES   = 2;
    localparam int unsigned NCH     = N / LANES;
    localparam int unsigned ACC_W   = 17;
    localparam longint      ACC_MAX = (longint'(1) << ACC_W) - 1;

    typedef struct packed {
        logic [7:0]  uid;
        logic [15:0] price;
        logic [15:0] qty;
    } entry_t;

    typedef struct {
        int               due;
        logic [ACC_W-1:0] qty;
        logic             stale;
    } rsp_t;

    logic             clk;
    logic             rst_n;
    logic             ins_vld;
    entry_t           ins_tbl;
    logic             ins_rdy;
    logic             head_pop;
    logic             head_upt;
    entry_t           head_upt_tbl;
    logic             head_vld_r;
    logic [39:0]      head_r;
    logic             cancel;
    logic [7:0]       cancel_uid;
    logic             cancel_hit_w;
    logic [39:0]      cancel_hit_tbl_w;
    logic             full_r;
    logic             empty_r;
    logic             qry_vld;
    logic [15:0]      qry_price;
    logic             qry_rdy;
    logic             qry_rsp_vld_r;
    logic [ACC_W-1:0] qry_rsp_qty_r;
    logic             qry_rsp_stale_r;
`ifdef OB_LM_TABLE_STATS_EN
    logic [2:0]       occ_r;
    logic [2:0]       hwm_r;
    logic [15:0]      ins_rej_cnt_r;
`endif

    ob_lm_table #(
        .N       (N),
        .LANES   (LANES),
        .IS_BID  (1'b1),
        .UID_W   (8),
        .PRICE_W (16),
        .QTY_W   (16),
        .ACC_W   (ACC_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ins_vld          (ins_vld),
        .ins_tbl          (ins_tbl),
        .ins_rdy          (ins_rdy),
        .head_pop         (head_pop),
        .head_upt         (head_upt),
        .head_upt_tbl     (head_upt_tbl),
        .head_vld_r       (head_vld_r),
        .head_r           (head_r),
        .cancel           (cancel),
        .cancel_uid       (cancel_uid),
        .cancel_hit_w     (cancel_hit_w),
        .cancel_hit_tbl_w (cancel_hit_tbl_w),
        .full_r           (full_r),
        .empty_r          (empty_r),
        .qry_vld          (qry_vld),
        .qry_price        (qry_price),
        .qry_rdy          (qry_rdy),
        .qry_rsp_vld_r    (qry_rsp_vld_r),
        .qry_rsp_qty_r    (qry_rsp_qty_r),
        .qry_rsp_stale_r  (qry_rsp_stale_r)
`ifdef OB_LM_TABLE_STATS_EN
        ,
        .occ_r            (occ_r),
        .hwm_r            (hwm_r),
        .ins_rej_cnt_r    (ins_rej_cnt_r)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    entry_t m[$];
    rsp_t   rsp_q[$];
    int     n_chk;
    int     n_fail;
    int     cyc;
    bit     qbusy;
    int     qchunk;
    logic [15:0] qprice;
    longint qsum;
    bit     qstale;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_inputs();
        ins_vld      = 1'b0;
        ins_tbl      = '0;
        head_pop     = 1'b0;
        head_upt     = 1'b0;
        head_upt_tbl = '0;
        cancel       = 1'b0;
        cancel_uid   = '0;
        qry_vld      = 1'b0;
        qry_price    = '0;
    endtask

    function automatic longint chunk_sum(input int c, input logic [15:0] thr);
        longint s = 0;
        for (int j = c * LANES; j < (c + 1) * LANES; j++) begin
            if (j < m.size() && m[j].price >= thr) s += m[j].qty;
        end
        return s;
    endfunction

    // One clock cycle: predict, compare combinational outputs, advance model, compare state
    task automatic tick();
        int     hk = -1;
        bit     exp_hit, exp_rdy, exp_qrdy, scan, commit;
        entry_t exp_htbl = '0;
        int     p;
        rsp_t   r;
        if (cancel && !head_pop) begin
            for (int i = 0; i < m.size(); i++) begin
                if (m[i].uid == cancel_uid) begin hk = i; break; end
            end
        end
        exp_hit  = (hk >= 0);
        if (exp_hit) exp_htbl = m[hk];
        exp_rdy  = (m.size() != N) && !head_pop && !exp_hit && !head_upt;
        exp_qrdy = !qbusy;
        scan     = 1'b0;
        if (!qbusy && qry_vld) begin
            qbusy = 1'b1; qchunk = 0; qprice = qry_price; qsum = 0; qstale = 1'b0;
        end
        if (qbusy) begin
            scan = 1'b1;
            qsum += chunk_sum(qchunk, qprice);
        end
        @(negedge clk);
        chk("ins_rdy", ins_rdy, exp_rdy);
        chk("cancel_hit_w", cancel_hit_w, exp_hit);
        chk("cancel_hit_tbl_w", cancel_hit_tbl_w, exp_htbl);
        chk("qry_rdy", qry_rdy, exp_qrdy);
        commit = 1'b0;
        if (head_pop) begin
            if (m.size() > 0) begin void'(m.pop_front()); commit = 1'b1; end
        end else if (exp_hit) begin
            m.delete(hk); commit = 1'b1;
        end else if (head_upt) begin
            if (m.size() > 0) begin m[0] = head_upt_tbl; commit = 1'b1; end
        end else if (ins_vld && exp_rdy) begin
            p = 0;
            foreach (m[i]) if (m[i].price >= ins_tbl.price) p++;
            m.insert(p, ins_tbl);
            commit = 1'b1;
        end
        if (scan) begin
            qstale |= commit;
            if (qchunk == NCH - 1) begin
                r.due = cyc + 1;
                r.qty = (qsum > ACC_MAX) ? ACC_W'(ACC_MAX) : ACC_W'(qsum);
                r.stale = qstale;
                rsp_q.push_back(r);
                qbusy = 1'b0;
            end else begin
                qchunk++;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        chk("head_vld_r", head_vld_r, m.size() > 0);
        chk("empty_r", empty_r, m.size() == 0);
        chk("full_r", full_r, m.size() == N);
        if (m.size() > 0) chk("head_r", head_r, m[0]);
    endtask

    task automatic monitor();
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rsp_q.size() > 0 && rsp_q[0].due < cyc) begin
                r = rsp_q.pop_front();
                n_chk++;
                n_fail++;
                $display("FAIL qry_rsp_missing: no pulse, expected at cycle %0d (now %0d)", r.due, cyc);
            end
            if (qry_rsp_vld_r) begin
                if (rsp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL qry_rsp_unexpected: pulse with qty 0x%0h, expected none (cycle %0d)",
                             qry_rsp_qty_r, cyc);
                end else begin
                    r = rsp_q.pop_front();
                    chk("qry_rsp_cycle", cyc, r.due);
                    chk("qry_rsp_qty_r", qry_rsp_qty_r, r.qty);
                    chk("qry_rsp_stale_r", qry_rsp_stale_r, r.stale);
                end
            end
        end
    endtask

    task automatic do_ins(input logic [7:0] u, input logic [15:0] p, input logic [15:0] q);
        clear_inputs();
        ins_vld = 1'b1;
        ins_tbl = {u, p, q};
        tick();
        clear_inputs();
    endtask

    task automatic do_reset_mid_cycle();
        rst_n = 1'b0;
        m.delete();
        rsp_q.delete();
        qbusy = 1'b0;
        clear_inputs();
        #1;
        chk("rst_empty_r", empty_r, 1'b1);
        chk("rst_full_r", full_r, 1'b0);
        chk("rst_head_vld_r", head_vld_r, 1'b0);
        chk("rst_qry_rdy", qry_rdy, 1'b1);
        chk("rst_qry_rsp_vld_r", qry_rsp_vld_r, 1'b0);
        chk("rst_qry_rsp_qty_r", qry_rsp_qty_r, '0);
        chk("rst_qry_rsp_stale_r", qry_rsp_stale_r, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        qbusy  = 1'b0;
        clear_inputs();
        rst_n = 1'b1;
        fork
            monitor();
        join_none
        @(posedge clk);
        #1;
        do_reset_mid_cycle();

        // Sorted insert with FIFO among equal prices
        do_ins(8'd1, 16'd10, 16'd9);
        do_ins(8'd2, 16'd30, 16'd5);
        do_ins(8'd3, 16'd20, 16'd2);
        do_ins(8'd7, 16'd30, 16'd3);
        chk("full_after_fill", full_r, 1'b1);
        do_ins(8'd9, 16'd40, 16'd1);

        clear_inputs(); qry_vld = 1'b1; qry_price = 16'd20; tick();
        clear_inputs(); tick(); tick();

        clear_inputs(); cancel = 1'b1; cancel_uid = 8'd7; tick();
        clear_inputs(); cancel = 1'b1; cancel_uid = 8'd99; tick();
        do_ins(8'd7, 16'd30, 16'd3);

        // Full table: pop wins over insert, insert lands the next cycle
        clear_inputs(); ins_vld = 1'b1; ins_tbl = {8'd5, 16'd25, 16'd4}; head_pop = 1'b1; tick();
        clear_inputs(); ins_vld = 1'b1; ins_tbl = {8'd5, 16'd25, 16'd4}; tick();

        clear_inputs(); qry_vld = 1'b1; qry_price = 16'd0; tick();
        clear_inputs(); head_pop = 1'b1; tick();
        clear_inputs(); tick(); tick();

        clear_inputs(); head_upt = 1'b1; head_upt_tbl = m[0]; head_upt_tbl.qty = 16'd1; tick();
        for (int i = 0; i < N + 1; i++) begin
            clear_inputs(); head_pop = 1'b1; tick();
        end

        for (int c = 0; c < 3000; c++) begin
            clear_inputs();
            if ($urandom_range(1, 0) == 1) begin
                ins_vld = 1'b1;
                ins_tbl.uid   = 8'($urandom_range(15, 0));
                ins_tbl.price = 16'(10 * $urandom_range(5, 1));
                ins_tbl.qty   = ($urandom_range(3, 0) == 0) ? 16'($urandom_range(65535, 60000))
                                                            : 16'($urandom_range(100, 1));
            end
            if ($urandom_range(99, 0) < 15) head_pop = 1'b1;
            if ($urandom_range(99, 0) < 15) begin
                cancel = 1'b1;
                if (m.size() > 0 && $urandom_range(1, 0) == 1)
                    cancel_uid = m[$urandom_range(m.size() - 1, 0)].uid;
                else
                    cancel_uid = 8'($urandom_range(15, 0));
            end
            if ($urandom_range(99, 0) < 10 && m.size() > 0) begin
                head_upt = 1'b1;
                head_upt_tbl = m[0];
                head_upt_tbl.qty = 16'($urandom_range(65535, 1));
            end
            if ($urandom_range(99, 0) < 30) begin
                qry_vld = 1'b1;
                qry_price = 16'($urandom_range(55, 5));
            end
            tick();
        end

        // Reset during a scan with a full table aborts the response
        clear_inputs(); tick(); tick(); tick();
        for (int i = 0; i < 8 && m.size() < N; i++) begin
            do_ins(8'(20 + i), 16'(15 + i), 16'd50);
        end
        clear_inputs(); qry_vld = 1'b1; qry_price = 16'd0; tick();
        do_reset_mid_cycle();
        clear_inputs();
        for (int i = 0; i < 4; i++) tick();

        chk("rsp_queue_drained", rsp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
